// File: rtl/alu_pkg.sv
// Shared ALU types and sizing for the multiplier sequencer.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

endpackage

// File: rtl/alu_mul_zdet.sv
// Remaining-multiplier zero detector: flags when every multiplier bit still
// to be consumed is zero and reports how many shift steps are left.
module alu_mul_zdet
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] mplier,
    input  logic [CNT_W-1:0] count,
    output logic             zero,
    output logic [CNT_W-1:0] remain
);

    // Only the low (WIDTH-count) bits are multiplier bits; above them sit product bits.
    always_comb begin
        remain = CNT_W'(WIDTH) - count;
        zero   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < int'(remain)) && mplier[i]) begin
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the ALU's external CLA adder.
// Optional early termination on an exhausted multiplier: ALU_MUL_EARLY_TERM_EN.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    mul_state_t           state;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     m;
    logic [CNT_W-1:0]     count;
    logic                 accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);
    assign product   = p;

    // The adder only sees live operands while iterating; otherwise it idles at zero.
    assign add_a   = (state == RUN) ? p[2*WIDTH-1:WIDTH] : '0;
    assign add_b   = ((state == RUN) && p[0]) ? m : '0;
    assign add_cin = 1'b0;

`ifdef ALU_MUL_EARLY_TERM_EN
    logic             zero;
    logic [CNT_W-1:0] remain;

    alu_mul_zdet #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_zdet (
        .mplier (p[WIDTH-1:0]),
        .count  (count),
        .zero   (zero),
        .remain (remain)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            m     <= '0;
            count <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        p     <= {{WIDTH{1'b0}}, b};
                        m     <= a;
                        count <= '0;
                        state <= RUN;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
`ifdef ALU_MUL_EARLY_TERM_EN
                    // Remaining steps would only add zero, so collapse them into one shift.
                    if (zero) begin
                        p     <= p >> remain;
                        state <= DONE;
                    end else
`endif
                    begin
                        p     <= {add_cout, add_sum, p[WIDTH-1:1]};
                        count <= count + 1'b1;
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
